// File: rtl/lif_spike_monitor_pkg.sv
// Shared types and constants for the LIF spike monitor: state width, default
// counter widths and the ISI measurement state encoding.
package lif_spike_monitor_pkg;

    localparam int STATE_W   = 8;
    localparam int CNT_W_DEF = 8;
    localparam int ISI_W_DEF = 16;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } isi_state_t;

    function automatic logic [STATE_W-1:0] max_state(input logic [STATE_W-1:0] a,
                                                     input logic [STATE_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lif_spike_monitor_if.sv
// Neuron-to-monitor bundle: neuron spike/state in, rate/peak/ISI reports out.
interface lif_spike_monitor_if
    import lif_spike_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ISI_W = ISI_W_DEF
);
    logic               ena;
    logic               spike_in;
    logic [STATE_W-1:0] state_in;
    logic [CNT_W-1:0]   rate_out;
    logic [STATE_W-1:0] peak_out;
    logic               rate_valid;
    logic [ISI_W-1:0]   isi_out;
    logic               isi_valid;

    modport master (
        output ena, spike_in, state_in,
        input  rate_out, peak_out, rate_valid, isi_out, isi_valid
    );

    modport slave (
        input  ena, spike_in, state_in,
        output rate_out, peak_out, rate_valid, isi_out, isi_valid
    );
endinterface

// File: rtl/lif_spike_monitor_sat_counter.sv
// Saturating up-counter with clear, load-to-one and increment (that priority).
module lif_spike_monitor_sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_load1,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // Counter register: sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load1) begin
            r_q <= W'(1'b1);
        end else if (i_inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1'b1);
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/lif_spike_monitor.sv
// Spike monitor: per-window spike rate and peak membrane state, plus the
// interval between the last two spike events, all as registered reports.
module lif_spike_monitor
    import lif_spike_monitor_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 24'd10_000_000,
    parameter int          CNT_W         = CNT_W_DEF,
    parameter int          ISI_W         = ISI_W_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    lif_spike_monitor_if.slave  bus
);
    localparam int              WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic               r_spike_q;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [STATE_W-1:0] r_peak;
    isi_state_t         r_isi_state;
    isi_state_t         w_isi_state_next;
    logic [CNT_W-1:0]   w_spk_cnt;
    logic [ISI_W-1:0]   w_isi_cnt;
    logic               w_event;
    logic               w_terminal;
    logic               w_isi_load1;
    logic               w_isi_inc;
    logic               w_isi_capture;
    logic [CNT_W-1:0]   w_rate_next;
    logic [STATE_W-1:0] w_peak_next;
    logic [CNT_W-1:0]   r_rate_out;
    logic [STATE_W-1:0] r_peak_out;
    logic               r_rate_valid;
    logic [ISI_W-1:0]   r_isi_out;
    logic               r_isi_valid;

    // The edge reference tracks spike_in even while disabled, so an edge seen during ena=0 is lost.
    assign w_event     = bus.ena & bus.spike_in & ~r_spike_q;
    assign w_terminal  = bus.ena & (r_win_cnt == WIN_LAST);
    assign w_peak_next = max_state(r_peak, bus.state_in);
    assign w_rate_next = (w_event && (w_spk_cnt != {CNT_W{1'b1}})) ?
                         (w_spk_cnt + CNT_W'(1'b1)) : w_spk_cnt;

    lif_spike_monitor_sat_counter #(.W(CNT_W)) u_spk_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_terminal),
        .i_load1 (1'b0),
        .i_inc   (w_event),
        .o_q     (w_spk_cnt)
    );

    lif_spike_monitor_sat_counter #(.W(ISI_W)) u_isi_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_load1 (w_isi_load1),
        .i_inc   (w_isi_inc),
        .o_q     (w_isi_cnt)
    );

    // Edge reference, window position and running peak.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_spike_q <= 1'b0;
            r_win_cnt <= '0;
            r_peak    <= '0;
        end else begin
            r_spike_q <= bus.spike_in;
            if (w_terminal) begin
                r_win_cnt <= '0;
                r_peak    <= '0;
            end else if (bus.ena) begin
                r_win_cnt <= r_win_cnt + WIN_W'(1'b1);
                r_peak    <= w_peak_next;
            end else begin
                r_win_cnt <= r_win_cnt;
                r_peak    <= r_peak;
            end
        end
    end

    // ISI state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_isi_state <= S_IDLE;
        end else begin
            r_isi_state <= w_isi_state_next;
        end
    end

    // ISI next state: the first event only arms; later events report and restart at 1.
    always_comb begin
        w_isi_state_next = r_isi_state;
        w_isi_load1      = 1'b0;
        w_isi_inc        = 1'b0;
        w_isi_capture    = 1'b0;
        case (r_isi_state)
            S_IDLE: begin
                if (w_event) begin
                    w_isi_state_next = S_ARMED;
                    w_isi_load1      = 1'b1;
                end else begin
                    w_isi_state_next = S_IDLE;
                end
            end
            S_ARMED: begin
                if (w_event) begin
                    w_isi_load1   = 1'b1;
                    w_isi_capture = 1'b1;
                end else if (bus.ena) begin
                    w_isi_inc = 1'b1;
                end else begin
                    w_isi_inc = 1'b0;
                end
            end
            default: begin
                w_isi_state_next = S_IDLE;
            end
        endcase
    end

    // Report registers: data holds between one-cycle strobes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rate_out   <= '0;
            r_peak_out   <= '0;
            r_rate_valid <= 1'b0;
            r_isi_out    <= '0;
            r_isi_valid  <= 1'b0;
        end else begin
            r_rate_valid <= w_terminal;
            r_isi_valid  <= w_isi_capture;
            if (w_terminal) begin
                r_rate_out <= w_rate_next;
                r_peak_out <= w_peak_next;
            end else begin
                r_rate_out <= r_rate_out;
                r_peak_out <= r_peak_out;
            end
            if (w_isi_capture) begin
                r_isi_out <= w_isi_cnt;
            end else begin
                r_isi_out <= r_isi_out;
            end
        end
    end

    assign bus.rate_out   = r_rate_out;
    assign bus.peak_out   = r_peak_out;
    assign bus.rate_valid = r_rate_valid;
    assign bus.isi_out    = r_isi_out;
    assign bus.isi_valid  = r_isi_valid;
endmodule

// File: tb/tb_lif_spike_monitor.sv
// Bench: two monitors (16-cycle window / 16-bit ISI, 600-cycle window / 4-bit ISI)
// share one stimulus stream and are compared every cycle against a timestamp model.
module tb_lif_spike_monitor;
    localparam int NDUT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lif_spike_monitor_if #(.CNT_W(8), .ISI_W(16)) bus_a ();
    lif_spike_monitor_if #(.CNT_W(8), .ISI_W(4))  bus_b ();

    lif_spike_monitor #(.WINDOW_CYCLES(16), .CNT_W(8), .ISI_W(16)) dut_a (
        .i_clk(clk), .i_reset(reset), .bus(bus_a.slave));
    lif_spike_monitor #(.WINDOW_CYCLES(600), .CNT_W(8), .ISI_W(4)) dut_b (
        .i_clk(clk), .i_reset(reset), .bus(bus_b.slave));

    // Reference model: events are timestamped by enabled-cycle index since reset.
    int unsigned win_len [NDUT] = '{16, 600};
    int unsigned isi_max [NDUT] = '{65535, 15};
    longint      en_idx     [NDUT];
    longint      last_evt   [NDUT];
    int          win_events [NDUT];
    int          win_peak   [NDUT];
    int          exp_rate   [NDUT];
    int          exp_peak   [NDUT];
    int          exp_isi    [NDUT];
    bit          exp_rv     [NDUT];
    bit          exp_iv     [NDUT];
    bit          prev_spike;
    int          checks = 0;
    int          errors = 0;

    task automatic model_cycle(input bit rst, input bit en, input bit sp, input int st);
        for (int d = 0; d < NDUT; d++) begin
            exp_rv[d] = 1'b0;
            exp_iv[d] = 1'b0;
            if (rst) begin
                en_idx[d] = 0; last_evt[d] = -1; win_events[d] = 0; win_peak[d] = 0;
                exp_rate[d] = 0; exp_peak[d] = 0; exp_isi[d] = 0;
            end else if (en) begin
                if (sp && !prev_spike) begin
                    win_events[d]++;
                    if (last_evt[d] >= 0) begin
                        longint diff = en_idx[d] - last_evt[d];
                        exp_isi[d] = (diff > longint'(isi_max[d])) ? int'(isi_max[d]) : int'(diff);
                        exp_iv[d]  = 1'b1;
                    end
                    last_evt[d] = en_idx[d];
                end
                if (st > win_peak[d]) win_peak[d] = st;
                if ((en_idx[d] % longint'(win_len[d])) == longint'(win_len[d]) - 1) begin
                    exp_rate[d]   = (win_events[d] > 255) ? 255 : win_events[d];
                    exp_peak[d]   = win_peak[d];
                    exp_rv[d]     = 1'b1;
                    win_events[d] = 0;
                    win_peak[d]   = 0;
                end
                en_idx[d]++;
            end
        end
        prev_spike = rst ? 1'b0 : sp;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_rate_valid", 32'(bus_a.rate_valid), 32'(exp_rv[0]));
        chk("a_rate_out",   32'(bus_a.rate_out),   32'(exp_rate[0]));
        chk("a_peak_out",   32'(bus_a.peak_out),   32'(exp_peak[0]));
        chk("a_isi_valid",  32'(bus_a.isi_valid),  32'(exp_iv[0]));
        chk("a_isi_out",    32'(bus_a.isi_out),    32'(exp_isi[0]));
        chk("b_rate_valid", 32'(bus_b.rate_valid), 32'(exp_rv[1]));
        chk("b_rate_out",   32'(bus_b.rate_out),   32'(exp_rate[1]));
        chk("b_peak_out",   32'(bus_b.peak_out),   32'(exp_peak[1]));
        chk("b_isi_valid",  32'(bus_b.isi_valid),  32'(exp_iv[1]));
        chk("b_isi_out",    32'(bus_b.isi_out),    32'(exp_isi[1]));
    endtask

    task automatic step(input bit rst, input bit en, input bit sp, input logic [7:0] st);
        reset          = rst;
        bus_a.ena      = en;  bus_b.ena      = en;
        bus_a.spike_in = sp;  bus_b.spike_in = sp;
        bus_a.state_in = st;  bus_b.state_in = st;
        model_cycle(rst, en, sp, int'(st));
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // Reset with spike high and full-scale state: nothing may leak through.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("t1_rate_rst", 32'(bus_a.rate_out), 32'd0);
        chk("t1_isi_rst",  32'(bus_a.isi_out),  32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, (i < 15), 8'h10);
        chk("t1_held_level", 32'(bus_a.rate_out), 32'd1);

        // Pulses at window cycles 0,4,8,12 with a ramping state.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, (i % 4 == 0), 8'(i * 10 + 6));
        chk("t2_rate", 32'(bus_a.rate_out), 32'd4);
        chk("t2_peak", 32'(bus_a.peak_out), 32'h9C);

        // ISI from events at 5, 12 and a terminal-cycle event at 15.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, (i == 5 || i == 12 || i == 15), 8'(i));
            if (i == 5)  chk("t3_no_first_isi", 32'(bus_a.isi_valid), 32'd0);
            if (i == 12) chk("t3_isi_7", 32'(bus_a.isi_out), 32'd7);
        end
        chk("t3_terminal_rate", 32'(bus_a.rate_out), 32'd3);
        chk("t3_terminal_isi",  32'(bus_a.isi_out),  32'd3);

        // Ten disabled cycles with a rising edge inside them.
        for (int i = 0; i < 5; i++)  step(1'b0, 1'b1, (i == 2), 8'h11);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, (i >= 3 && i < 6), 8'hF0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, (i == 4), 8'h20);
        chk("t5_rate", 32'(bus_a.rate_out),   32'd2);
        chk("t5_peak", 32'(bus_a.peak_out),   32'h20);
        chk("t5_rv",   32'(bus_a.rate_valid), 32'd1);
        chk("t5_isi",  32'(bus_a.isi_out),    32'd7);

        // Randomized traffic, including disabled cycles.
        for (int i = 0; i < 400; i++)
            step(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0), 8'($urandom));

        // Rate saturation on the long window, then ISI saturation on the 4-bit counter.
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 600; i++) step(1'b0, 1'b1, (i % 2 == 0), 8'(i));
        chk("t4_rate_sat", 32'(bus_b.rate_out),   32'd255);
        chk("t4_rv",       32'(bus_b.rate_valid), 32'd1);
        for (int i = 0; i < 19; i++) step(1'b0, 1'b1, (i == 18), 8'h00);
        chk("t4_isi_sat", 32'(bus_b.isi_out), 32'd15);
        chk("t4_isi_20",  32'(bus_a.isi_out), 32'd20);

        // Reset mid-window after two events discards the window and the ISI.
        step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, (i == 2 || i == 5), 8'h40);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("t6_rate_rst", 32'(bus_a.rate_out), 32'd0);
        chk("t6_peak_rst", 32'(bus_a.peak_out), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, (i == 3), 8'h07);
        chk("t6_rate_new", 32'(bus_a.rate_out), 32'd1);
        chk("t6_peak_new", 32'(bus_a.peak_out), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
